// File: rtl/lenet_pkg.sv
// Shared LeNet constants and the layer-6 weight loader state encoding.
package lenet_pkg;

  localparam int W6_LANES = 84;
  localparam int W6_DEPTH = 120;
  localparam int W6_AW    = 7;
  localparam int DW       = 8;

  typedef enum logic [2:0] {
    W6_IDLE  = 3'd0,
    W6_LOAD  = 3'd1,
    W6_WRITE = 3'd2,
    W6_CHECK = 3'd3,
    W6_DONE  = 3'd4
  } w6_state_e;

endpackage

// File: rtl/w6_pack_shreg.sv
// Byte-insert shift register that assembles one weight RAM word.
// New bytes enter at the top lane, so the first byte of a word ends up in lane 0.
module w6_pack_shreg #(
  parameter int LANES = lenet_pkg::W6_LANES,
  parameter int DW    = lenet_pkg::DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [DW-1:0]         din_i,
  output logic [LANES*DW-1:0]   q_o
);

  logic [LANES*DW-1:0] pack_q;

  // Shift right by one byte and insert the accepted byte at the top on each enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q <= '0;
    end else if (en_i) begin
      pack_q <= {din_i, pack_q[LANES*DW-1:DW]};
    end
  end

  assign q_o = pack_q;

endmodule

// File: rtl/w6_loader.sv
// Layer-6 weight RAM loader: packs a byte stream into 672-bit words and writes
// them to addresses 0..DEPTH-1. Optional trailing checksum byte is enabled by
// the macro W6_LOADER_CHECKSUM_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start after reset
// LOAD     | accepting bytes of the current word (in_ready=1)
// WRITE    | single-cycle RAM write of the packed word
// CHECK    | accepting the checksum trailer byte (macro build only)
// DONE     | sequence complete, done held until the next start
module w6_loader #(
  parameter int LANES = lenet_pkg::W6_LANES,
  parameter int DEPTH = lenet_pkg::W6_DEPTH,
  parameter int AW    = lenet_pkg::W6_AW,
  parameter int DW    = lenet_pkg::DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  w6_wen,
  output logic [AW-1:0]         w6_waddr,
  output logic [LANES*DW-1:0]   w6_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  import lenet_pkg::*;

  localparam logic [6:0]    LAST_BYTE = 7'(LANES - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  w6_state_e     state_q;
  logic [AW-1:0] addr_q;
  logic [6:0]    cnt_q;
  logic          in_ready_q;
  logic          wen_q;
  logic          busy_q;
  logic          done_q;
  logic          pack_en;

`ifdef W6_LOADER_CHECKSUM_EN
  logic [DW-1:0] sum_q;
  logic          err_q;
`endif

  // Only bytes accepted while loading a word reach the pack register; the
  // checksum trailer must not disturb the last written word.
  assign pack_en = (state_q == W6_LOAD) && in_valid && in_ready_q;

  w6_pack_shreg #(
    .LANES (LANES),
    .DW    (DW)
  ) u_pack (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pack_en),
    .din_i (in_data),
    .q_o   (w6_wdata)
  );

  // Sequencer: byte counting, address stepping, write strobe and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= W6_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      wen_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef W6_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      wen_q <= 1'b0;
      case (state_q)
        W6_IDLE, W6_DONE: begin
          if (start) begin
            state_q    <= W6_LOAD;
            addr_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
`ifdef W6_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
          end
        end
        W6_LOAD: begin
          if (in_valid && in_ready_q) begin
`ifdef W6_LOADER_CHECKSUM_EN
            sum_q <= sum_q + in_data;
`endif
            if (cnt_q == LAST_BYTE) begin
              state_q    <= W6_WRITE;
              in_ready_q <= 1'b0;
              wen_q      <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 7'd1;
            end
          end
        end
        W6_WRITE: begin
          cnt_q <= '0;
          if (addr_q == LAST_ADDR) begin
`ifdef W6_LOADER_CHECKSUM_EN
            state_q    <= W6_CHECK;
            in_ready_q <= 1'b1;
`else
            state_q    <= W6_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else begin
            addr_q     <= addr_q + ADDR_ONE;
            state_q    <= W6_LOAD;
            in_ready_q <= 1'b1;
          end
        end
`ifdef W6_LOADER_CHECKSUM_EN
        W6_CHECK: begin
          if (in_valid && in_ready_q) begin
            err_q      <= (in_data != sum_q);
            state_q    <= W6_DONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
`endif
        default: begin
          state_q    <= W6_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign w6_wen   = wen_q;
  assign w6_waddr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef W6_LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_w6_loader.sv
// Self-checking bench for w6_loader: full loads with and without input gaps,
// ignored start pulses, mid-load reset, restart after done, and (when
// W6_LOADER_CHECKSUM_EN is defined) the checksum trailer.
module tb_w6_loader;

  localparam int LANES  = 84;
  localparam int DEPTH  = 120;
  localparam int NBYTES = LANES * DEPTH;
`ifdef W6_LOADER_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         w6_wen;
  logic [6:0]   w6_waddr;
  logic [671:0] w6_wdata;
  logic         busy;
  logic         done;
  logic         err;

  w6_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .w6_wen   (w6_wen),
    .w6_waddr (w6_waddr),
    .w6_wdata (w6_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Byte source for one load sequence; index NBYTES holds the checksum trailer.
  logic [7:0] src [NBYTES+1];

  // RAM image and write log captured from the write port.
  logic [671:0] ram [128];
  int           wr_addr_q[$];
  int           wen_double = 0;
  logic         prev_wen = 1'b0;

  always @(negedge clk) begin
    if (w6_wen === 1'b1) begin
      ram[w6_waddr] = w6_wdata;
      wr_addr_q.push_back(int'(w6_waddr));
      if (prev_wen) wen_double++;
    end
    prev_wen = (w6_wen === 1'b1);
  end

  // mode 0: (addr*84+lane) mod 256, 1: all 0x01, 2: random. Trailer = byte sum mod 256.
  task automatic fill(input int mode);
    int s;
    s = 0;
    for (int i = 0; i < NBYTES; i++) begin
      case (mode)
        0:       src[i] = 8'(i % 256);
        1:       src[i] = 8'h01;
        default: src[i] = 8'($urandom);
      endcase
      s += int'(src[i]);
    end
    src[NBYTES] = 8'(s % 256);
  endtask

  task automatic clear_log();
    for (int a = 0; a < 128; a++) ram[a] = '0;
    wr_addr_q.delete();
    wen_double = 0;
  endtask

  // Expected RAM word: lane l holds byte a*84+l of the stream.
  function automatic logic [671:0] model_word(input int a);
    logic [671:0] w;
    w = '0;
    for (int l = 0; l < LANES; l++) w[l*8 +: 8] = src[a*LANES + l];
    return w;
  endfunction

  // Issues a start pulse and streams bytes until done, a byte limit, or a cycle budget.
  task automatic run_load(input int duty, input bit inject, input int stop_at,
                          input string tag, output int done_t, output int nbytes);
    int idx;
    int t;
    int busy_drops;
    idx = 0;
    busy_drops = 0;
    done_t = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, longint'(busy), 1);
    check({tag, "_ready_after_start"}, longint'(in_ready), 1);
    check({tag, "_done_cleared"}, longint'(done), 0);
    check({tag, "_err_cleared"}, longint'(err), 0);
    t = 1;
    while (t < 40000) begin
      if (done) begin
        done_t = t;
        break;
      end
      if (!busy) busy_drops++;
      if (stop_at >= 0 && idx == stop_at) break;
      start    = inject && (w6_wen || ($urandom_range(0, 199) == 0));
      in_valid = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      in_data  = (idx <= NBYTES) ? src[idx] : 8'h00;
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      t++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    nbytes   = idx;
    check({tag, "_busy_held"}, busy_drops, 0);
    if (stop_at < 0) begin
      check({tag, "_done_seen"}, longint'(done_t != -1), 1);
      check({tag, "_bytes_consumed"}, nbytes, NBYTES + EXTRA);
    end
  endtask

  task automatic check_image(input string tag);
    int sbad;
    int wbad;
    sbad = 0;
    wbad = 0;
    check({tag, "_nwrites"}, wr_addr_q.size(), DEPTH);
    for (int i = 0; i < wr_addr_q.size(); i++) if (wr_addr_q[i] != i) sbad++;
    check({tag, "_addr_seq"}, sbad, 0);
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== model_word(a)) wbad++;
    check({tag, "_image_words_bad"}, wbad, 0);
    check({tag, "_wen_back_to_back"}, wen_double, 0);
  endtask

  typedef struct {
    int         addr;
    logic [7:0] lo;
    logic [7:0] hi;
  } vec_t;

  vec_t vecs [4];

  task automatic check_vectors(input string tag);
    for (int v = 0; v < 4; v++) begin
      check($sformatf("%s_w%0d_lane1", tag, vecs[v].addr), longint'(ram[vecs[v].addr][7:0]),
            longint'(vecs[v].lo));
      check($sformatf("%s_w%0d_lane84", tag, vecs[v].addr), longint'(ram[vecs[v].addr][671:664]),
            longint'(vecs[v].hi));
    end
  endtask

  initial begin
    int dt;
    int nb;
    int hi_writes;

    vecs[0] = '{0,   8'h00, 8'h53};
    vecs[1] = '{1,   8'h54, 8'hA7};
    vecs[2] = '{60,  8'hB0, 8'h03};
    vecs[3] = '{119, 8'h0C, 8'h5F};

    repeat (3) @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_wen", longint'(w6_wen), 0);
    check("rst_waddr", longint'(w6_waddr), 0);
    check("rst_wdata_zero", longint'(w6_wdata === '0), 1);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_err", longint'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", longint'(in_ready), 0);

    // Gap-free load of the counting pattern.
    fill(0);
    clear_log();
    run_load(100, 1'b0, -1, "full", dt, nb);
    check("full_done_cycle", dt, 10201 + EXTRA);
    check("full_err", longint'(err), 0);
    check_image("full");
    check_vectors("full");

    // Same pattern with 50% valid duty and start pulses during LOAD and WRITE.
    clear_log();
    run_load(50, 1'b1, -1, "gaps", dt, nb);
    check("gaps_err", longint'(err), 0);
    check_image("gaps");
    check_vectors("gaps");

    // Reset after byte 40 of word 5.
    clear_log();
    run_load(100, 1'b0, 5*LANES + 40, "rst", dt, nb);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", longint'(in_ready), 0);
    check("midrst_wen", longint'(w6_wen), 0);
    check("midrst_waddr", longint'(w6_waddr), 0);
    check("midrst_wdata_zero", longint'(w6_wdata === '0), 1);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_done", longint'(done), 0);
    repeat (3) @(negedge clk);
    hi_writes = 0;
    foreach (wr_addr_q[i]) if (wr_addr_q[i] >= 5) hi_writes++;
    check("midrst_nwrites", wr_addr_q.size(), 5);
    check("midrst_no_addr5", hi_writes, 0);
    rst_n = 1'b1;

    // Fresh load of random bytes after the reset.
    fill(2);
    clear_log();
    run_load(100, 1'b0, -1, "fresh", dt, nb);
    check("fresh_done_cycle", dt, 10201 + EXTRA);
    check("fresh_err", longint'(err), 0);
    check_image("fresh");

`ifdef W6_LOADER_CHECKSUM_EN
    fill(1);
    src[NBYTES] = 8'h60;
    clear_log();
    run_load(100, 1'b0, -1, "ck_good", dt, nb);
    check("ck_good_done", longint'(done), 1);
    check("ck_good_err", longint'(err), 0);
    check_image("ck_good");
    src[NBYTES] = 8'h61;
    clear_log();
    run_load(100, 1'b0, -1, "ck_bad", dt, nb);
    check("ck_bad_done", longint'(done), 1);
    check("ck_bad_err", longint'(err), 1);
    check_image("ck_bad");
`endif

    repeat (2) @(negedge clk);
    check("final_done_held", longint'(done), 1);
    check("final_busy", longint'(busy), 0);
    check("final_in_ready", longint'(in_ready), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
